// File: rtl/vec_intr_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
package vec_intr_pkg;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam int         DEF_N_IRQ      = 8;
  localparam int         DEF_ADDR_W     = 8;
  localparam logic [7:0] DEF_VEC_BASE   = 8'h80;
  localparam logic [7:0] DEF_VEC_STRIDE = 8'h10;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pri_encoder_n.sv
// N-input priority encoder; the lowest set index wins, valid flags any set bit.
module pri_encoder_n import vec_intr_pkg::*; #(
  parameter int N = 8,
  parameter int W = id_w(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  // Scan downwards so the last hit (the lowest index) is what remains.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vec_intr_ctrl.sv
// Maskable, vectored, nestable priority interrupt controller with ack/EOI handshake.
module vec_intr_ctrl import vec_intr_pkg::*; #(
  parameter int                N_IRQ      = DEF_N_IRQ,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(DEF_VEC_STRIDE)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [N_IRQ-1:0]         irq_in,
  input  logic [N_IRQ-1:0]         edge_mode,
  input  logic                     mask_we,
  input  logic [N_IRQ-1:0]         mask_in,
  input  logic                     vec_we,
  input  logic [$clog2(N_IRQ)-1:0] vec_idx,
  input  logic [ADDR_W-1:0]        vec_addr,
  input  logic                     itr_en,
  input  logic                     ack,
  input  logic                     eoi,
  output logic                     i_pending,
  output logic [ADDR_W-1:0]        PC_out,
  output logic [$clog2(N_IRQ)-1:0] irq_id,
  output logic [N_IRQ-1:0]         ITR_register,
  output logic [N_IRQ-1:0]         MASK_register,
  output logic [N_IRQ-1:0]         ISR_register
);
  localparam int ID_W = $clog2(N_IRQ);

  logic [N_IRQ-1:0]  pend, mask, isr, irq_q;
  logic [N_IRQ-1:0]  prio_lim, cand_req, ack_clr, isr_n;
  logic [ADDR_W-1:0] vec_tbl [N_IRQ];
  logic [ID_W-1:0]   cand_id, isr_top;
  logic              cand_vld, isr_vld, load, ack_fire;
  state_t            state, state_n;

  pri_encoder_n #(.N(N_IRQ), .W(ID_W)) u_isr_enc (
    .req(isr), .idx(isr_top), .valid(isr_vld)
  );

  // Only channels strictly above the highest in-service one may preempt it.
  always_comb begin
    prio_lim = '1;
    for (int i = 0; i < N_IRQ; i++)
      prio_lim[i] = !isr_vld || (i < int'(isr_top));
  end

  assign cand_req = pend & mask & prio_lim;

  pri_encoder_n #(.N(N_IRQ), .W(ID_W)) u_cand_enc (
    .req(cand_req), .idx(cand_id), .valid(cand_vld)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    ack_fire = 1'b0;
    case (state)
      IDLE: if (itr_en && cand_vld) begin
        state_n = REQ;
        load    = 1'b1;
      end
      REQ: if (ack) begin
        state_n  = IDLE;
        ack_fire = 1'b1;
      end else if (!itr_en) begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ack_clr = ack_fire ? (N_IRQ'(1) << irq_id) : '0;

  // EOI retires against the old ISR before the accepted channel is marked.
  always_comb begin
    isr_n = isr;
    if (eoi && isr_vld) isr_n[isr_top] = 1'b0;
    if (ack_fire)       isr_n[irq_id]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      pend   <= '0;
      mask   <= '0;
      isr    <= '0;
      irq_q  <= '0;
      PC_out <= VEC_BASE;
      irq_id <= '0;
      for (int i = 0; i < N_IRQ; i++)
        vec_tbl[i] <= VEC_BASE + ADDR_W'(i) * VEC_STRIDE;
    end else begin
      state <= state_n;
      irq_q <= irq_in;
      isr   <= isr_n;
      // A fresh edge beats a same-cycle ack clear; level channels just track the pin.
      pend  <= (edge_mode & ((irq_in & ~irq_q) | (pend & ~ack_clr)))
             | (~edge_mode & irq_in);
      if (mask_we) mask <= mask_in;
      if (vec_we && int'(vec_idx) < N_IRQ) vec_tbl[vec_idx] <= vec_addr;
      if (load) begin
        PC_out <= vec_tbl[cand_id];
        irq_id <= cand_id;
      end
    end
  end

  assign i_pending     = (state == REQ);
  assign ITR_register  = pend;
  assign MASK_register = mask;
  assign ISR_register  = isr;
endmodule
